// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, operand/result widths and sequencer FSM states shared with the ALU front end.
package alu_pkg;
   localparam int ALU_OPND_W = 3;
   localparam int ALU_RES_W  = 4;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: registers commands onto the external ALU, captures its result with flags and keeps an accumulator.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_opcode,
   input  logic [ALU_OPND_W-1:0] cmd_a,
   input  logic [ALU_OPND_W-1:0] cmd_b,
   input  logic                  cmd_use_acc,
   input  logic                  acc_clr,
   output logic [ALU_OPND_W-1:0] alu_a,
   output logic [ALU_OPND_W-1:0] alu_b,
   output logic [1:0]            alu_opcode,
   input  logic [ALU_RES_W-1:0]  alu_z,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [ALU_RES_W-1:0]  res_z,
   output logic                  res_carry,
   output logic                  res_zero,
   output logic [ALU_OPND_W-1:0] acc,
   output logic [CNT_W-1:0]      op_count
);
   state_t                  state_q, state_d;
   logic [ALU_OPND_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d, acc_q, acc_d, acc_fwd;
   logic [1:0]              alu_op_q, alu_op_d;
   logic [ALU_RES_W-1:0]    res_z_q, res_z_d;
   logic                    carry_q, carry_d, zero_q, zero_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    res_hs, cmd_hs, exec;

   always_comb begin
      exec      = state_q == EXEC;
      res_hs    = state_q == RESP && res_ready;
      cmd_ready = state_q == IDLE || res_hs;
      cmd_hs    = cmd_valid && cmd_ready;
      // A chained command sees the result being consumed this cycle, ignoring a simultaneous clear
      acc_fwd   = res_hs ? res_z_q[ALU_OPND_W-1:0] : acc_q;
      acc_d     = acc_clr ? '0 : acc_fwd;
      state_d   = cmd_hs ? EXEC : exec ? RESP : res_hs ? IDLE : state_q;
      alu_a_d   = cmd_hs ? (cmd_use_acc ? acc_fwd : cmd_a) : alu_a_q;
      alu_b_d   = cmd_hs ? cmd_b : alu_b_q;
      alu_op_d  = cmd_hs ? cmd_opcode : alu_op_q;
      res_z_d   = exec ? alu_z : res_z_q;
      carry_d   = exec ? ~alu_op_q[1] & alu_z[ALU_RES_W-1] : carry_q;
      zero_d    = exec ? alu_z[ALU_OPND_W-1:0] == '0 : zero_q;
      cnt_d     = cnt_q + CNT_W'(res_hs);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         res_z_q  <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         res_z_q  <= res_z_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_opcode = alu_op_q;
   assign res_valid  = state_q == RESP;
   assign res_z      = res_z_q;
   assign res_carry  = carry_q;
   assign res_zero   = zero_q;
   assign acc        = acc_q;
   assign op_count   = cnt_q;
endmodule
